// File: rtl/digit_feature_recog.sv
// Counts 0->1 stroke crossings on one column and two rows of a fixed character
// window, then decodes the three counts into a digit at every frame boundary.
module digit_feature_recog #(
    parameter logic [11:0] REGION_LEFT  = 12'd70,
    parameter logic [11:0] REGION_RIGHT = 12'd140,
    parameter logic [11:0] REGION_UP    = 12'd80,
    parameter logic [11:0] REGION_DOWN  = 12'd190,
    parameter logic [11:0] COL_H2       = 12'd105,
    parameter logic [11:0] ROW_V5       = 12'd115,
    parameter logic [11:0] ROW_V3       = 12'd150
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  logic        i_bin,
    output logic [3:0]  reco_digital,
    output logic [11:0] h_2,
    output logic [11:0] v_5,
    output logic [11:0] v_3,
    output logic        o_valid
);

    typedef enum logic {ACCUM = 1'b0, DECODE = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        vs_dly_q, vs_dly_d;
    logic [3:0]  c_h2_q, c_h2_d, c_v5_q, c_v5_d, c_v3_q, c_v3_d;
    logic        l5_q, l5_d, l3_q, l3_d;
    logic        seen5_q, seen5_d, seen3_q, seen3_d;
    logic        prev_h2_q, prev_h2_d, prev_v5_q, prev_v5_d, prev_v3_q, prev_v3_d;
    logic [3:0]  reco_q, reco_d;
    logic [11:0] h2_q, h2_d, v5_q, v5_d, v3_q, v3_d;
    logic        valid_q, valid_d;

    logic in_win, vs_rise, row_prev5, row_prev3;

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == 4'hF) ? c : c + 4'd1;
    endfunction

    function automatic logic [3:0] decode_digit(input logic [3:0] ch, input logic [3:0] cv5,
                                                input logic [3:0] cv3, input logic fl5,
                                                input logic fl3);
        logic [3:0] d;
        d = 4'hF;
        if      (ch == 4'd3 && cv5 == 4'd2 && cv3 == 4'd2)                 d = 4'd8;
        else if (ch == 4'd2 && cv5 == 4'd2 && cv3 == 4'd2)                 d = 4'd0;
        else if (ch == 4'd3 && cv5 == 4'd1 && cv3 == 4'd1 && !fl5 && fl3)  d = 4'd2;
        else if (ch == 4'd3 && cv5 == 4'd1 && cv3 == 4'd1 && !fl5 && !fl3) d = 4'd3;
        else if (ch == 4'd3 && cv5 == 4'd1 && cv3 == 4'd1 && fl5 && !fl3)  d = 4'd5;
        else if (ch == 4'd2 && cv5 == 4'd2 && cv3 == 4'd1)                 d = 4'd4;
        else if (ch == 4'd3 && cv5 == 4'd1 && cv3 == 4'd2)                 d = 4'd6;
        else if (ch == 4'd3 && cv5 == 4'd2 && cv3 == 4'd1)                 d = 4'd9;
        else if (ch == 4'd2 && cv5 == 4'd1 && cv3 == 4'd1)                 d = 4'd7;
        else if (ch == 4'd1 && cv5 == 4'd1 && cv3 == 4'd1)                 d = 4'd1;
        return d;
    endfunction

    assign in_win  = i_de && (x >= REGION_LEFT) && (x <= REGION_RIGHT)
                          && (y >= REGION_UP) && (y <= REGION_DOWN);
    assign vs_rise = i_vs & ~vs_dly_q;
    // Each row scan starts fresh at the left edge of the window.
    assign row_prev5 = (x == REGION_LEFT) ? 1'b0 : prev_v5_q;
    assign row_prev3 = (x == REGION_LEFT) ? 1'b0 : prev_v3_q;

    always_comb begin
        state_d   = state_q;
        vs_dly_d  = i_vs;
        c_h2_d    = c_h2_q;
        c_v5_d    = c_v5_q;
        c_v3_d    = c_v3_q;
        l5_d      = l5_q;
        l3_d      = l3_q;
        seen5_d   = seen5_q;
        seen3_d   = seen3_q;
        prev_h2_d = prev_h2_q;
        prev_v5_d = prev_v5_q;
        prev_v3_d = prev_v3_q;
        reco_d    = reco_q;
        h2_d      = h2_q;
        v5_d      = v5_q;
        v3_d      = v3_q;
        valid_d   = 1'b0;

        if (state_q == DECODE) begin
            state_d   = ACCUM;
            h2_d      = {8'd0, c_h2_q};
            v5_d      = {8'd0, c_v5_q};
            v3_d      = {8'd0, c_v3_q};
            reco_d    = decode_digit(c_h2_q, c_v5_q, c_v3_q, l5_q, l3_q);
            valid_d   = 1'b1;
            c_h2_d    = 4'd0;
            c_v5_d    = 4'd0;
            c_v3_d    = 4'd0;
            l5_d      = 1'b0;
            l3_d      = 1'b0;
            seen5_d   = 1'b0;
            seen3_d   = 1'b0;
            prev_h2_d = 1'b0;
        end else begin
            if (vs_rise) state_d = DECODE;
            // The pixel arriving with the vs edge still belongs to the closing frame.
            if (in_win) begin
                if (x == COL_H2) begin
                    if (i_bin && !prev_h2_q) c_h2_d = sat_inc(c_h2_q);
                    prev_h2_d = i_bin;
                end
                if (y == ROW_V5) begin
                    if (i_bin && !row_prev5) begin
                        c_v5_d = sat_inc(c_v5_q);
                        if (!seen5_q) begin
                            seen5_d = 1'b1;
                            l5_d    = (x < COL_H2);
                        end
                    end
                    prev_v5_d = i_bin;
                end
                if (y == ROW_V3) begin
                    if (i_bin && !row_prev3) begin
                        c_v3_d = sat_inc(c_v3_q);
                        if (!seen3_q) begin
                            seen3_d = 1'b1;
                            l3_d    = (x < COL_H2);
                        end
                    end
                    prev_v3_d = i_bin;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACCUM;
            vs_dly_q  <= 1'b0;
            c_h2_q    <= 4'd0;
            c_v5_q    <= 4'd0;
            c_v3_q    <= 4'd0;
            l5_q      <= 1'b0;
            l3_q      <= 1'b0;
            seen5_q   <= 1'b0;
            seen3_q   <= 1'b0;
            prev_h2_q <= 1'b0;
            prev_v5_q <= 1'b0;
            prev_v3_q <= 1'b0;
            reco_q    <= 4'hF;
            h2_q      <= 12'd0;
            v5_q      <= 12'd0;
            v3_q      <= 12'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            vs_dly_q  <= vs_dly_d;
            c_h2_q    <= c_h2_d;
            c_v5_q    <= c_v5_d;
            c_v3_q    <= c_v3_d;
            l5_q      <= l5_d;
            l3_q      <= l3_d;
            seen5_q   <= seen5_d;
            seen3_q   <= seen3_d;
            prev_h2_q <= prev_h2_d;
            prev_v5_q <= prev_v5_d;
            prev_v3_q <= prev_v3_d;
            reco_q    <= reco_d;
            h2_q      <= h2_d;
            v5_q      <= v5_d;
            v3_q      <= v3_d;
            valid_q   <= valid_d;
        end
    end

    assign reco_digital = reco_q;
    assign h_2          = h2_q;
    assign v_5          = v5_q;
    assign v_3          = v3_q;
    assign o_valid      = valid_q;

endmodule

// File: doc/digit_feature_recog.md
# digit_feature_recog

Upstream of the character/picture overlay stage. Scans a binarized video stream inside a fixed character window and counts stroke crossings along three feature lines. At every frame boundary it decodes the counts into a digit. It outputs `reco_digital` and the three feature counts `h_2`, `v_5` and `v_3`, registered and held stable for the whole next frame, so the overlay can draw them.

## Interface
- `REGION_LEFT`, 70: first x column of the character window (inclusive).
- `REGION_RIGHT`, 140: last x column of the window (inclusive).
- `REGION_UP`, 80: first y row of the window (inclusive).
- `REGION_DOWN`, 190: last y row of the window (inclusive).
- `COL_H2`, 105: x column scanned vertically for the `h_2` count.
- `ROW_V5`, 115: y row scanned horizontally for the `v_5` count.
- `ROW_V3`, 150: y row scanned horizontally for the `v_3` count.
- `clk` in 1: pixel clock; only clock.
- `rst` in 1: asynchronous, active-high reset.
- `i_vs` in 1: vertical sync, active high; a rising edge marks the frame boundary.
- `i_de` in 1: data enable; a pixel is valid only when high.
- `x` in 12: current pixel column.
- `y` in 12: current pixel row.
- `i_bin` in 1: binarized pixel; 1 = stroke (foreground).
- `reco_digital` out 4: decoded digit 0–9; 4'hF = no match.
- `h_2` out 12: crossings counted down column `COL_H2`, zero-extended.
- `v_5` out 12: crossings counted along row `ROW_V5`, zero-extended.
- `v_3` out 12: crossings counted along row `ROW_V3`, zero-extended.
- `o_valid` out 1: one-cycle pulse when new outputs are loaded.

## Operation
- **In-window pixel:** `i_de`=1 and `REGION_LEFT`≤x≤`REGION_RIGHT` and `REGION_UP`≤y≤`REGION_DOWN`.
- **Crossing:** a 0→1 transition of `i_bin` between consecutive in-window pixels on a feature line.
  - Row lines: the previous-pixel register is forced to 0 at x==`REGION_LEFT`.
  - Column line: the previous-pixel register updates only on in-window pixels with x==`COL_H2`, and is cleared at the frame boundary.
- **Accumulators:** three 4-bit crossing counters `c_h2`, `c_v5`, `c_v3`, each saturating at 15.
- **Side flags:** per row, `l5` and `l3` record whether the first crossing on that row occurred at x<`COL_H2`. Each flag is set once per frame at the first crossing and cleared at the frame boundary.
- **State machine:**
  - ACCUM → DECODE on a detected rising edge of `i_vs`. Edge detect: `i_vs` & ~`vs_d`, where `vs_d` is `i_vs` registered.
  - DECODE → ACCUM unconditionally after 1 cycle.
  - In DECODE: latch the counts into `h_2`/`v_5`/`v_3`, load the decoded digit into `reco_digital`, pulse `o_valid`, and clear counters, flags and the column previous-pixel register.
  - Pixels presented during the DECODE cycle are ignored.
- **Decode**, as a tuple (`c_h2`,`c_v5`,`c_v3`), first match wins:
  - (3,2,2) → 8
  - (2,2,2) → 0
  - (3,1,1) with `l5`=0, `l3`=1 → 2
  - (3,1,1) with `l5`=0, `l3`=0 → 3
  - (3,1,1) with `l5`=1, `l3`=0 → 5
  - (2,2,1) → 4
  - (3,1,2) → 6
  - (3,2,1) → 9
  - (2,1,1) → 7
  - (1,1,1) → 1
  - anything else → 4'hF
- **Reset:**
  - Outputs: `reco_digital`=4'hF, `h_2`=`v_5`=`v_3`=0, `o_valid`=0.
  - Internal: counters and flags 0, state ACCUM, `vs_d`=0.
  - A reset mid-frame discards the partial frame. Counting resumes on the next pixels, and the first decode follows the next `i_vs` rising edge.

## Timing
- Pixel inputs are sampled on the `clk` rising edge. Counter updates take effect the cycle after the qualifying pixel.
- `i_vs` is sampled at edge T; DECODE occupies cycle T+1. Outputs and the `o_valid` pulse are visible after edge T+1 (1-cycle latency from the sampled edge).
- Outputs hold until the next DECODE. `o_valid` is high for exactly one cycle per frame.
- A pixel that is in-window in the same cycle `i_vs` rises is still counted into the closing frame.
- Counter saturation: a 16th crossing leaves the count at 15. The decode then yields 4'hF unless the tuple matches a table entry.

## Test plan
- **Reset:** assert `rst` mid-frame → all outputs at reset values immediately (asynchronous). No `o_valid` until the first `i_vs` edge after release.
- **Digit 0 image:**
  - Stimulus: ring stroke. Column 105 is foreground for y 85–89 and 185–189. Rows 115 and 150 are foreground at x 75–79 and 130–134.
  - Required: `h_2`=2, `v_5`=2, `v_3`=2, `reco_digital`=0, a single `o_valid` one cycle after the sampled `i_vs` edge.
- **Digit 2 image:**
  - Stimulus: column 105 has 3 strokes; row 115 stroke at x 130; row 150 stroke at x 80.
  - Required: (3,1,1), `l5`=0, `l3`=1 → `reco_digital`=2.
- **Blank frame:** all `i_bin`=0 → counts 0, `reco_digital`=4'hF. Then a digit-8 frame → 8; values hold unchanged between pulses.
- **Boundaries and saturation:**
  - Stroke at x=69 on row 115 → not counted. Stroke at x=70 → counted.
  - 20 alternating strokes on row 115 → `v_5`=15, `reco_digital`=4'hF.
- **`i_de` gating and edge alignment:**
  - `i_de`=0 with `i_bin`=1 on the feature lines → no counts.
  - Qualifying pixel in the same cycle as the `i_vs` rise → counted in the closing frame.
